// File: rtl/pipe_hazard_sched_pkg.sv
// Shared types and constants for the pipeline hazard scheduler.
package pipe_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN      = 2'd0;
    localparam state_t ST_MEM_WAIT = 2'd1;
    localparam state_t ST_ERROR    = 2'd2;

    // Bit positions inside the per-stage Op field.
    localparam int unsigned OP_REGWRITE = 2;
    localparam int unsigned OP_MEMREAD  = 1;
    localparam int unsigned OP_MEMWRITE = 0;
    localparam logic [2:0]  OP_NOP      = 3'b000;

    function automatic logic load_use(
        input logic       ex_valid,
        input logic       ex_memread,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rs1,
        input logic [4:0] id_rs2,
        input logic       id_use_rs2
    );
        return ex_valid && ex_memread && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs1) || (id_use_rs2 && (ex_rd == id_rs2)));
    endfunction

endpackage

// File: rtl/pipe_hazard_sched_if.sv
// Bundle between the pipeline datapath (master) and the hazard scheduler (slave).
interface pipe_hazard_sched_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             id_use_rs2_i;
    logic             id_branch_taken_i;
    logic [4:0]       ex_rd_i;
    logic             ex_memread_i;
    logic             ex_valid_i;
    logic             mem_req_i;
    logic             dmem_ack_i;
    logic             dmem_req_o;
    logic             pc_we_o;
    logic             ifid_we_o;
    logic             exmem_we_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             memwb_bubble_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             timeout_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_use_rs2_i, id_branch_taken_i,
        output ex_rd_i, ex_memread_i, ex_valid_i, mem_req_i, dmem_ack_i,
        input  dmem_req_o, pc_we_o, ifid_we_o, exmem_we_o, ifid_flush_o,
        input  idex_bubble_o, memwb_bubble_o, stall_cnt_o, flush_cnt_o, timeout_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_use_rs2_i, id_branch_taken_i,
        input  ex_rd_i, ex_memread_i, ex_valid_i, mem_req_i, dmem_ack_i,
        output dmem_req_o, pc_we_o, ifid_we_o, exmem_we_o, ifid_flush_o,
        output idex_bubble_o, memwb_bubble_o, stall_cnt_o, flush_cnt_o, timeout_o
    );
endinterface

// File: rtl/pipe_hazard_sched_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_hazard_sched.sv
// Per-cycle capture/hold/bubble control for the 5-stage pipeline buffers,
// plus data-memory handshake sequencing and stall/flush performance counters.
module pipe_hazard_sched
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input logic                clk_i,
    input logic                rst_i,
    pipe_hazard_sched_if.slave bus
);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              lu, mf, in_wait;
    logic              pc_we, ifid_we, exmem_we, ifid_flush;
    logic              idex_bubble, memwb_bubble, dmem_req;
    logic              stall_inc, flush_inc;

    assign lu = load_use(bus.ex_valid_i, bus.ex_memread_i, bus.ex_rd_i,
                         bus.id_rs1_i, bus.id_rs2_i, bus.id_use_rs2_i);

    always_comb begin
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        exmem_we     = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b1;
        memwb_bubble = 1'b1;
        dmem_req     = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        state_d      = state_q;
        wait_d       = wait_q;
        in_wait      = (state_q == ST_MEM_WAIT);
        mf           = 1'b0;

        // Reset and ERROR both fall through to the safe defaults above.
        if (!rst_i && (state_q == ST_RUN || state_q == ST_MEM_WAIT)) begin
            dmem_req = in_wait | bus.mem_req_i;
            mf       = in_wait ? !bus.dmem_ack_i : (bus.mem_req_i && !bus.dmem_ack_i);

            if (mf) begin
                idex_bubble  = 1'b0;
                memwb_bubble = 1'b1;
                stall_inc    = 1'b1;
            end else if (lu) begin
                exmem_we     = 1'b1;
                memwb_bubble = 1'b0;
                stall_inc    = 1'b1;
            end else begin
                pc_we        = 1'b1;
                ifid_we      = 1'b1;
                exmem_we     = 1'b1;
                idex_bubble  = 1'b0;
                memwb_bubble = 1'b0;
                ifid_flush   = bus.id_branch_taken_i;
                flush_inc    = bus.id_branch_taken_i;
            end

            if (in_wait) begin
                if (bus.dmem_ack_i) begin
                    state_d = ST_RUN;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (wait_d >= WAIT_W'(MEM_TIMEOUT)) begin
                        state_d = ST_ERROR;
                    end
                end
            end else if (mf) begin
                state_d = ST_MEM_WAIT;
                wait_d  = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_inc),
        .cnt_o (bus.stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_inc),
        .cnt_o (bus.flush_cnt_o)
    );

    assign bus.pc_we_o        = pc_we;
    assign bus.ifid_we_o      = ifid_we;
    assign bus.exmem_we_o     = exmem_we;
    assign bus.ifid_flush_o   = ifid_flush;
    assign bus.idex_bubble_o  = idex_bubble;
    assign bus.memwb_bubble_o = memwb_bubble;
    assign bus.dmem_req_o     = dmem_req;
    assign bus.timeout_o      = (state_q == ST_ERROR);
endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Randomised + directed bench for pipe_hazard_sched with a queue-based scoreboard.
module tb_pipe_hazard_sched;
    localparam int CNT_W = 4;
    localparam int TMO   = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use2;
        logic       br;
        logic [4:0] rd;
        logic       mrd;
        logic       exv;
        logic       req;
        logic       ack;
    } stim_t;

    typedef struct packed {
        logic [6:0]       ctrl; // pc, ifid, exmem, flush, idex_b, memwb_b, dmem
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
        logic             tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_sched_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_sched #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference model: plain flags and integer counts.
    bit   m_err  = 0;
    bit   m_wait = 0;
    int   m_wcnt = 0;
    int   m_stall = 0;
    int   m_flush = 0;

    task automatic drive(input stim_t s);
        exp_t e;
        bit   lu, mf;
        @(posedge clk);
        #1;
        rst                   = s.rst;
        bus.id_rs1_i          = s.rs1;
        bus.id_rs2_i          = s.rs2;
        bus.id_use_rs2_i      = s.use2;
        bus.id_branch_taken_i = s.br;
        bus.ex_rd_i           = s.rd;
        bus.ex_memread_i      = s.mrd;
        bus.ex_valid_i        = s.exv;
        bus.mem_req_i         = s.req;
        bus.dmem_ack_i        = s.ack;

        e.stall = CNT_W'(m_stall);
        e.flush = CNT_W'(m_flush);
        e.tmo   = m_err;
        if (s.rst || m_err) begin
            e.ctrl = 7'b0000110;
            if (s.rst) begin
                m_err = 0; m_wait = 0; m_wcnt = 0; m_stall = 0; m_flush = 0;
            end
        end else begin
            lu = s.exv && s.mrd && s.rd != 0 &&
                 (s.rd == s.rs1 || (s.use2 && s.rd == s.rs2));
            mf = m_wait ? !s.ack : (s.req && !s.ack);
            if (mf)      e.ctrl = {6'b000001, 1'b0};
            else if (lu) e.ctrl = {6'b001010, 1'b0};
            else         e.ctrl = {3'b111, s.br, 2'b00, 1'b0};
            e.ctrl[0] = m_wait || s.req;
            if (mf || lu) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (!mf && !lu && s.br) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            if (m_wait) begin
                if (s.ack) m_wait = 0;
                else begin
                    m_wcnt++;
                    if (m_wcnt >= TMO) begin m_err = 1; m_wait = 0; end
                end
            end else if (mf) begin
                m_wait = 1;
                m_wcnt = 0;
            end
        end
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t  e;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            cyc++;
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {bus.pc_we_o, bus.ifid_we_o, bus.exmem_we_o, bus.ifid_flush_o,
                       bus.idex_bubble_o, bus.memwb_bubble_o, bus.dmem_req_o};
                n_tests += 3;
                if (act !== e.ctrl) begin
                    n_fail++;
                    $display("FAIL ctrl cyc=%0d got=%b exp=%b (pc,ifid,exmem,flush,idexb,memwbb,req)",
                             cyc, act, e.ctrl);
                end
                if (bus.stall_cnt_o !== e.stall || bus.flush_cnt_o !== e.flush) begin
                    n_fail++;
                    $display("FAIL counters cyc=%0d got stall=%0d flush=%0d exp stall=%0d flush=%0d",
                             cyc, bus.stall_cnt_o, bus.flush_cnt_o, e.stall, e.flush);
                end
                if (bus.timeout_o !== e.tmo) begin
                    n_fail++;
                    $display("FAIL timeout cyc=%0d got=%b exp=%b", cyc, bus.timeout_o, e.tmo);
                end
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        bus.id_rs1_i = '0; bus.id_rs2_i = '0; bus.id_use_rs2_i = 1'b0;
        bus.id_branch_taken_i = 1'b0; bus.ex_rd_i = '0; bus.ex_memread_i = 1'b0;
        bus.ex_valid_i = 1'b0; bus.mem_req_i = 1'b0; bus.dmem_ack_i = 1'b0;
        repeat (2) @(posedge clk);

        s = '0; s.rst = 1'b1;
        drive(s); drive(s);

        // Load-use on rs1, then a normal cycle.
        s = '0; s.rs1 = 5; s.rd = 5; s.mrd = 1; s.exv = 1;
        drive(s);
        s = '0; s.rs1 = 5;
        drive(s);
        // Load to x0 never stalls.
        s = '0; s.rs1 = 0; s.rd = 0; s.mrd = 1; s.exv = 1;
        drive(s);
        // Load-use via rs2.
        s = '0; s.rs1 = 1; s.rs2 = 7; s.use2 = 1; s.rd = 7; s.mrd = 1; s.exv = 1;
        drive(s);
        // Taken branch, no hazard.
        s = '0; s.br = 1;
        drive(s);
        s = '0;
        drive(s);
        // Zero-wait memory access.
        s = '0; s.req = 1; s.ack = 1;
        drive(s);
        // 3-cycle ack with a branch frozen in ID.
        s = '0; s.req = 1; s.br = 1;
        repeat (3) drive(s);
        s.ack = 1;
        drive(s);
        s = '0;
        drive(s);
        // Timeout into ERROR, held until reset.
        s = '0; s.req = 1;
        repeat (7) drive(s);
        s = '0; s.rst = 1;
        drive(s);
        s = '0;
        drive(s);
        // Reset mid-wait drops the request.
        s = '0; s.req = 1;
        repeat (2) drive(s);
        s.rst = 1;
        drive(s);
        // Stall counter saturation.
        s = '0; s.rs1 = 3; s.rd = 3; s.mrd = 1; s.exv = 1;
        repeat (CMAX + 1 + 5) drive(s);
        s = '0; s.rst = 1;
        drive(s);

        for (int i = 0; i < 3000; i++) begin
            s.rst  = ($urandom_range(63) == 0) || (m_err && $urandom_range(7) == 0);
            s.rs1  = 5'($urandom_range(7));
            s.rs2  = 5'($urandom_range(7));
            s.use2 = 1'($urandom_range(1));
            s.br   = ($urandom_range(3) == 0);
            s.rd   = 5'($urandom_range(7));
            s.mrd  = 1'($urandom_range(1));
            s.exv  = ($urandom_range(3) != 0);
            s.req  = ($urandom_range(2) == 0) || m_wait;
            s.ack  = ($urandom_range(9) < 5);
            drive(s);
        end

        repeat (3) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d pending exp=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_sched.md
# pipe_hazard_sched

Pipeline scheduler for the 5-stage core: decides every cycle whether each pipeline buffer (IF/ID, ID/EX, EX/MEM, MEM/WB) captures, holds, or is bubbled. It detects load-use hazards, flushes on taken branches, and sequences the data-memory request/acknowledge handshake for the instruction held in EX/MEM. It also exports saturating stall and flush counters and a sticky memory-timeout flag.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum wait cycles for `dmem_ack_i` before the error state is entered.
- CNT_W, 16: width of the performance counters.

Ports:
- clk_i  in  1  single clock; all state updates on posedge.
- rst_i  in  1  synchronous, active-high reset.
- id_rs1_i, id_rs2_i  in  5  source registers of the instruction in ID.
- id_use_rs2_i  in  1  ID instruction reads rs2.
- id_branch_taken_i  in  1  branch resolved taken in ID.
- ex_rd_i  in  5  destination of the instruction in EX.
- ex_memread_i  in  1  EX instruction is a load.
- ex_valid_i  in  1  EX slot holds a real instruction.
- mem_req_i  in  1  EX/MEM holds a valid load or store (Op memread|memwrite && valid).
- dmem_ack_i  in  1  data memory completes the access this cycle.
- dmem_req_o  out  1  access request to data memory.
- pc_we_o, ifid_we_o, exmem_we_o  out  1  capture enables.
- ifid_flush_o  out  1  IF/ID loads a NOP.
- idex_bubble_o, memwb_bubble_o  out  1  force valid=0 into ID/EX and MEM/WB.
- stall_cnt_o, flush_cnt_o  out  CNT_W  saturating event counters.
- timeout_o  out  1  sticky memory-timeout flag.

## Operation
- States: RUN, MEM_WAIT, ERROR. Reset → RUN.
- Load-use hazard (lu) = ex_valid_i && ex_memread_i && ex_rd_i!=0 && (ex_rd_i==id_rs1_i || (id_use_rs2_i && ex_rd_i==id_rs2_i)).
- Memory freeze (mf) = RUN && mem_req_i && !dmem_ack_i, or MEM_WAIT && !dmem_ack_i.
- Priority: ERROR > mf > lu > branch flush > normal.
- ERROR: all enables 0, bubbles 1, dmem_req_o 0, timeout_o 1; leave only by reset.
- mf: pc_we/ifid_we/exmem_we 0, idex_bubble 0 (ID/EX holds), memwb_bubble 1, ifid_flush 0. RUN→MEM_WAIT.
- MEM_WAIT with ack: behave as RUN for this cycle (lu/branch evaluated, exmem_we 1, memwb_bubble 0); next state RUN.
- lu (no mf): pc_we 0, ifid_we 0, idex_bubble 1, exmem_we 1, ifid_flush 0 (a taken branch waits on its operands).
- Branch taken (no mf, no lu): all enables 1, ifid_flush 1.
- Normal: all enables 1, all flush/bubble 0.
- dmem_req_o = mem_req_i in RUN; 1 in MEM_WAIT; 0 in ERROR.
- Wait counter: cleared on MEM_WAIT entry, +1 per MEM_WAIT cycle without ack; reaching MEM_TIMEOUT → ERROR.
- stall_cnt +1 per cycle with mf or lu; flush_cnt +1 per ifid_flush cycle; both saturate at 2^CNT_W−1.

## Timing
- Control outputs combinational from state and inputs, same cycle; state/counters registered.
- While rst_i=1: enables 0, bubbles 1, ifid_flush 0, dmem_req_o 0. Post-reset: state RUN, counters 0, timeout_o 0.
- Load-use costs exactly 1 stall cycle; a taken branch costs 1 flushed slot.
- Zero-wait memory (ack with request): no stall. N-cycle ack: N stall cycles, release in the ack cycle.
- Branch asserted during MEM_WAIT is frozen in ID and acted on in the ack cycle; it is not counted during the freeze.
- Reset mid-MEM_WAIT: dmem_req_o drops in the reset cycle; the outstanding access is abandoned.

## Structure
- Package pipe_pkg: state enum, Op bit positions (OP_REGWRITE=2, OP_MEMREAD=1, OP_MEMWRITE=0), NOP encoding.
- Sub-module sat_counter (parameter W; inputs clk_i, rst_i, inc_i; output cnt_o), instantiated twice.

## Test plan
- Load x5 in EX, ID reads rs1=x5 → 1 cycle pc_we=0, idex_bubble=1, stall_cnt=1; next cycle normal.
- ex_rd_i=0 with load, id_rs1_i=0 → no stall.
- Taken branch, no hazard → ifid_flush=1 for 1 cycle, flush_cnt=1.
- mem_req_i with ack after 3 cycles, branch taken during wait → 3 freeze cycles (memwb_bubble=1), then flush in ack cycle; stall_cnt=3, flush_cnt=1.
- MEM_TIMEOUT=4, ack never → ERROR after 4 wait cycles, timeout_o=1 until rst_i; after reset, all counters 0.
- Force 2^CNT_W+5 stall cycles (CNT_W=4) → stall_cnt_o holds 15.
